// File: rtl/soc_system_led_pio_pkg.sv
// soc_system_led_pio_pkg: register map and parameter limits for the LED PWM PIO
package soc_system_led_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_DUTY_IDX = 3'd3;
  localparam logic [2:0] ADDR_DUTY_VAL = 3'd4;
  localparam logic [2:0] ADDR_OUTSET   = 3'd5;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd6;
  localparam logic [2:0] ADDR_STATUS   = 3'd7;
  localparam int DUTY_IDX_W     = 5;
  localparam int MAX_NUM_CH     = 32;
  localparam int MAX_DUTY_W     = 16;
  localparam int MAX_PRESCALE_W = 32;
endpackage

// File: rtl/soc_system_led_pwm_timebase.sv
// soc_system_led_pwm_timebase: shared prescaler and PWM counter with tick/wrap strobes
module soc_system_led_pwm_timebase #(
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  clr_i,
  output logic [DUTY_W-1:0]     pwm_cnt_o,
  output logic                  tick_o,
  output logic                  wrap_o
);
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0]     pwm_cnt_q, pwm_cnt_d;
  assign tick_o    = pre_cnt_q == prescale_i;
  assign wrap_o    = tick_o && &pwm_cnt_q;
  assign pwm_cnt_o = pwm_cnt_q;
  // next state: prescaler restarts on tick or on a PRESCALE write, pwm_cnt advances per tick
  always_comb begin
    pre_cnt_d = (clr_i || tick_o) ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = tick_o ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
  end
  // counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
endmodule

// File: rtl/soc_system_led_pwm_pio.sv
// soc_system_led_pwm_pio: Avalon-MM LED port with set/clear writes and per-channel PWM dimming (LED_PIO_SYNC_UPDATE_EN selects wrap-synchronised duty updates)
module soc_system_led_pwm_pio
  import soc_system_led_pio_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                DUTY_W     = 8,
  parameter int                PRESCALE_W = 16,
  parameter logic [NUM_CH-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] out_port
);
  logic                  we;
  logic [NUM_CH-1:0]     wd_ch, data_q, data_d, mode_q, out_q, lvl;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [DUTY_IDX_W-1:0] idx_q;
  logic [DUTY_W-1:0]     duty_q [NUM_CH];
  logic [DUTY_W-1:0]     duty_rd, pwm_cnt;
  logic                  tick, wrap, unused_bits;
`ifdef LED_PIO_SYNC_UPDATE_EN
  logic [DUTY_W-1:0]     shadow_q [NUM_CH];
  assign unused_bits = ^{tick, writedata};
`else
  assign unused_bits = ^{tick, wrap, writedata};
`endif
  assign we       = chipselect && !write_n;
  assign wd_ch    = writedata[NUM_CH-1:0];
  assign out_port = out_q;
  soc_system_led_pwm_timebase #(.DUTY_W(DUTY_W), .PRESCALE_W(PRESCALE_W)) u_tb (
    .clk        (clk),
    .reset      (reset),
    .prescale_i (prescale_q),
    .clr_i      (we && address == ADDR_PRESCALE),
    .pwm_cnt_o  (pwm_cnt),
    .tick_o     (tick),
    .wrap_o     (wrap)
  );
  // DATA next state: plain write, write-1-to-set, write-1-to-clear
  always_comb begin
    data_d = !we                    ? data_q :
             address == ADDR_DATA   ? wd_ch :
             address == ADDR_OUTSET ? data_q | wd_ch :
             address == ADDR_OUTCLR ? data_q & ~wd_ch : data_q;
  end
  // per-channel level: PWM-gated DATA in PWM mode, plain DATA otherwise; duty readback by index
  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lvl[i] = mode_q[i] ? data_q[i] && (pwm_cnt < duty_q[i]) : data_q[i];
`ifdef LED_PIO_SYNC_UPDATE_EN
      if (idx_q == DUTY_IDX_W'(i)) duty_rd = shadow_q[i];
`else
      if (idx_q == DUTY_IDX_W'(i)) duty_rd = duty_q[i];
`endif
    end
  end
  // control registers and the registered LED output
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_DATA;
      mode_q     <= '0;
      prescale_q <= '0;
      idx_q      <= '0;
      out_q      <= '0;
    end else begin
      data_q <= data_d;
      out_q  <= lvl;
      if (we && address == ADDR_MODE) mode_q <= wd_ch;
      if (we && address == ADDR_PRESCALE) prescale_q <= writedata[PRESCALE_W-1:0];
      if (we && address == ADDR_DUTY_IDX) idx_q <= writedata[DUTY_IDX_W-1:0];
    end
  end
  // duty storage; an out-of-range index matches no channel so the write is dropped
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef LED_PIO_SYNC_UPDATE_EN
      if (reset) begin
        shadow_q[i] <= '0;
        duty_q[i]   <= '0;
      end else begin
        if (we && address == ADDR_DUTY_VAL && idx_q == DUTY_IDX_W'(i)) shadow_q[i] <= writedata[DUTY_W-1:0];
        if (wrap) duty_q[i] <= shadow_q[i];
      end
`else
      if (reset) duty_q[i] <= '0;
      else if (we && address == ADDR_DUTY_VAL && idx_q == DUTY_IDX_W'(i)) duty_q[i] <= writedata[DUTY_W-1:0];
`endif
    end
  end
  // combinational read mux, zero-extended
  always_comb begin
    readdata = address == ADDR_DATA     ? 32'(data_q) :
               address == ADDR_MODE     ? 32'(mode_q) :
               address == ADDR_PRESCALE ? 32'(prescale_q) :
               address == ADDR_DUTY_IDX ? 32'(idx_q) :
               address == ADDR_DUTY_VAL ? 32'(duty_rd) :
               address == ADDR_STATUS   ? 32'(out_q) : 32'd0;
  end
endmodule
